// File: rtl/rq_arb_pkg.sv
// Shared types and constants for the PCIe RQ requester arbiter.
package rq_arb_pkg;

    typedef enum logic {
        RQ_ARB_IDLE = 1'b0,
        RQ_ARB_PASS = 1'b1
    } rq_arb_state_e;

    localparam int RQ_USER_WIDTH = 137;
    localparam int RQ_OUTS_W     = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j[IW-1:0]]) begin
                found = 1'b1;
                idx   = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rq_arbiter.sv
// Round-robin, packet-granular arbiter sharing the PCIe RQ stream among N_REQ requesters.
// Optional read budget enabled by defining RQ_ARB_READ_THROTTLE_EN.
//
// state        | meaning
// RQ_ARB_IDLE  | no grant; all readies and master valid low; arbitrating
// RQ_ARB_PASS  | granted requester wired straight through to the master port
module rq_arbiter
    import rq_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = RQ_USER_WIDTH,
    parameter int N_REQ      = 2,
    parameter int MAX_READS  = 32
) (
    input  logic                        user_clk,
    input  logic                        user_reset,

    input  logic [N_REQ*DATA_WIDTH-1:0] s_req_tdata,
    input  logic [N_REQ*KEEP_WIDTH-1:0] s_req_tkeep,
    input  logic [N_REQ*USER_WIDTH-1:0] s_req_tuser,
    input  logic [N_REQ-1:0]            s_req_tlast,
    input  logic [N_REQ-1:0]            s_req_tvalid,
    input  logic [N_REQ-1:0]            s_req_is_read,
    output logic [N_REQ-1:0]            s_req_tready,

    output logic [DATA_WIDTH-1:0]       m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]       m_axis_rq_tkeep,
    output logic [USER_WIDTH-1:0]       m_axis_rq_tuser,
    output logic                        m_axis_rq_tlast,
    output logic                        m_axis_rq_tvalid,
    input  logic [3:0]                  m_axis_rq_tready,

    input  logic                        rc_done,
    output logic [RQ_OUTS_W-1:0]        outstanding,
    output logic                        underflow
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    rq_arb_state_e          state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [RQ_OUTS_W-1:0]   outs_q, outs_d;
    logic                   underflow_q, underflow_d;

    logic [N_REQ-1:0]       elig;
    logic                   pick_found;
    logic [IW-1:0]          pick_idx;
    logic                   read_grant;
    logic                   done_ev;
    logic                   pkt_end;

    logic                   unused_rdy;
    assign unused_rdy = ^m_axis_rq_tready[3:1];

`ifdef RQ_ARB_READ_THROTTLE_EN
    logic budget_ok;
    assign budget_ok  = (outs_q < RQ_OUTS_W'(MAX_READS));
    assign elig       = s_req_tvalid & (~s_req_is_read | {N_REQ{budget_ok}});
    assign read_grant = (state_q == RQ_ARB_IDLE) && pick_found && s_req_is_read[pick_idx];
    assign done_ev    = rc_done;
`else
    logic unused_thr;
    assign unused_thr = ^{s_req_is_read, rc_done};
    assign elig       = s_req_tvalid;
    assign read_grant = 1'b0;
    assign done_ev    = 1'b0;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (elig),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Master side always follows the grant slice so reset drives slice 0.
    always_comb begin
        m_axis_rq_tdata  = s_req_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_rq_tkeep  = s_req_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_rq_tuser  = s_req_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
        m_axis_rq_tlast  = s_req_tlast[grant_q];
        m_axis_rq_tvalid = 1'b0;
        s_req_tready     = '0;
        if (state_q == RQ_ARB_PASS) begin
            m_axis_rq_tvalid      = s_req_tvalid[grant_q];
            s_req_tready[grant_q] = m_axis_rq_tready[0];
        end
    end

    assign pkt_end = (state_q == RQ_ARB_PASS) && s_req_tvalid[grant_q]
                     && m_axis_rq_tready[0] && s_req_tlast[grant_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            RQ_ARB_IDLE: begin
                if (pick_found) begin
                    state_d = RQ_ARB_PASS;
                    grant_d = pick_idx;
                end
            end
            RQ_ARB_PASS: begin
                if (pkt_end) begin
                    state_d  = RQ_ARB_IDLE;
                    rr_ptr_d = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = RQ_ARB_IDLE;
        endcase
    end

    // A grant and a completion in the same cycle cancel out.
    always_comb begin
        outs_d      = outs_q;
        underflow_d = underflow_q;
        case ({read_grant, done_ev})
            2'b10: outs_d = outs_q + 1'b1;
            2'b01: begin
                if (outs_q == '0) underflow_d = 1'b1;
                else              outs_d      = outs_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q     <= RQ_ARB_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            outs_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            outs_q      <= outs_d;
            underflow_q <= underflow_d;
        end
    end

    assign outstanding = outs_q;
    assign underflow   = underflow_q;

endmodule

// File: doc/rq_arbiter.md
# rq_arbiter

Round-robin arbiter that shares the PCIe requester-request (RQ) AXI-Stream interface among `N_REQ` DMA requesters. It sits between the requester engines and the RQ adapter. Each grant is held for one whole packet. Optionally, it throttles non-posted reads against a budget of outstanding completions; that budget is released by completion-done pulses from the RC path.

## Interface
Parameters:
- `DATA_WIDTH`, 512: stream data width.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: keep width.
- `USER_WIDTH`, 137: RQ tuser width.
- `N_REQ`, 2: number of requesters, 2..8.
- `MAX_READS`, 32: maximum outstanding read requests, 1..255.

Ports:
- `user_clk`  in  1: clock for all logic.
- `user_reset`  in  1: reset, asynchronous and active-high.
- `s_req_tdata`  in  `N_REQ*DATA_WIDTH`: requester data, slice i belongs to requester i.
- `s_req_tkeep`  in  `N_REQ*KEEP_WIDTH`: requester keep.
- `s_req_tuser`  in  `N_REQ*USER_WIDTH`: requester tuser.
- `s_req_tlast`  in  `N_REQ`: last beat of packet.
- `s_req_tvalid`  in  `N_REQ`: beat valid.
- `s_req_is_read`  in  `N_REQ`: packet is a non-posted read; qualified by tvalid on the first beat.
- `s_req_tready`  out  `N_REQ`: beat accepted.
- `m_axis_rq_tdata`, `_tkeep`, `_tuser`, `_tlast`, `_tvalid`  out: muxed stream toward the RQ adapter.
- `m_axis_rq_tready`  in  4: downstream ready; only bit 0 is used.
- `rc_done`  in  1: one-cycle pulse meaning one read request fully completed.
- `outstanding`  out  8: current outstanding read count.
- `underflow`  out  1: sticky; set when `rc_done` arrives while `outstanding`==0.

## Operation
- FSM states:
  - IDLE: all `s_req_tready`=0; `m_axis_rq_tvalid`=0.
  - PASS: the granted requester is connected combinationally to the master port.
- Eligibility of requester i: `s_req_tvalid[i]` and (`!s_req_is_read[i]` or `outstanding < MAX_READS`).
- IDLE with at least one eligible requester:
  - Pick the first eligible index at or after `rr_ptr`, modulo `N_REQ`.
  - Register the pick as `grant` and go to PASS.
  - If the picked packet is a read, `outstanding` +1 in the same edge.
- IDLE with no eligible requester: stay in IDLE.
- PASS:
  - `m_axis_rq_* = s_req_*[grant]`.
  - `s_req_tready[grant] = m_axis_rq_tready[0]`; all other readies are 0.
- PASS, on `tvalid & tready[0] & tlast`:
  - Go to IDLE.
  - `rr_ptr <= (grant+1) mod N_REQ`.
- A grant is never revoked mid-packet. Requester valid may drop mid-packet; the FSM waits in PASS.
- `outstanding` arithmetic:
  - +1 on a read grant; -1 on `rc_done`.
  - Both in the same cycle: unchanged.
  - `rc_done` at 0: count stays 0 and `underflow` is set.
  - Never exceeds `MAX_READS`; this is guaranteed by the eligibility rule.
- A read blocked by the budget does not block other requesters: a posted write at a later index is granted.
- Reset values:
  - FSM=IDLE, `grant`=0, `rr_ptr`=0.
  - `outstanding`=0, `underflow`=0.
  - All `s_req_tready`=0, `m_axis_rq_tvalid`=0.
  - Master data, keep, user and last are don't-care but driven from slice 0.
- Reset mid-packet: the FSM returns to IDLE immediately. The truncated packet is not completed; upstream is reset together with this block.

## Timing
- Arbitration costs exactly one IDLE cycle per packet.
- Back-to-back packets: at least one idle cycle between the tlast beat and the next first beat.
- PASS data path has zero latency: combinational valid, ready and data.
- `outstanding` updates on the clock edge after the grant or `rc_done` event. The eligibility check in a cycle uses the registered value.
- `underflow` is visible one cycle after the offending `rc_done`.

## Configuration
- `RQ_ARB_READ_THROTTLE_EN` defined:
  - Read budget, `outstanding` counter and `underflow` flag are active, as described above.
- `RQ_ARB_READ_THROTTLE_EN` undefined:
  - Eligibility is `s_req_tvalid[i]` only.
  - `s_req_is_read` and `rc_done` are ignored.
  - `outstanding` and `underflow` are tied to 0.

## Structure
- Shared package `rq_arb_pkg` holds:
  - the FSM state enum (`RQ_ARB_IDLE`, `RQ_ARB_PASS`);
  - the `RQ_USER_WIDTH`=137 constant;
  - the outstanding counter width constant (8).
- One sub-module, `rr_pick`: a combinational rotate-priority picker. Inputs: `req[N_REQ]`, `ptr`. Outputs: `found`, `idx`.
- The FSM, counter and muxes live in the top level.

## Test plan
Benches use `N_REQ`=2 and `MAX_READS`=2 unless stated.
- Single requester: req0 sends a 3-beat write with `tready` all 1.
  - Grant one cycle after valid; 3 beats pass unmodified.
  - Back in IDLE after tlast; `rr_ptr`=1.
- Fairness: both requesters continuously valid with 1-beat writes.
  - Output order is 0,1,0,1.
  - A new packet starts every 2 cycles.
- Backpressure: `m_axis_rq_tready` toggles 1,0 during a 4-beat packet from req1.
  - Exactly 4 handshakes; `s_req_tready[0]` stays 0 throughout.
- Read budget: req0 issues 3 reads with no `rc_done`.
  - The first 2 are granted and `outstanding`=2; the third is held.
  - A write from req1 is granted meanwhile.
  - One `rc_done` pulse allows the third read; `outstanding` ends at 2.
- Simultaneous events: a read grant and `rc_done` in the same cycle at `outstanding`=1.
  - Count stays 1.
  - `rc_done` at count 0 leaves count 0 and sets `underflow`=1, which holds until reset.
- Reset mid-packet: assert `user_reset` on beat 2 of 4.
  - The same cycle, asynchronously: `m_axis_rq_tvalid`=0 and all readies 0.
  - Registers: `outstanding`=0; after release, IDLE with grant resuming at req0.
